imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 2048, meaning the maximum number of instruction words accepted per load.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of the first written word.
REQ-003 The block SHALL have parameter BOOT_HOLD, default 1'b0, meaning the reset value of o_cpu_hold.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed in REQ-005 and REQ-006.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 i_start  input  1  single-cycle request to begin a load.
REQ-008 i_byte_valid  input  1  the byte on i_byte_data is valid.
REQ-009 i_byte_data  input  8  incoming load-stream byte.
REQ-010 o_byte_ready  output  1  the block accepts a byte this cycle.
REQ-011 o_imem_we  output  1  single-cycle instruction-memory write strobe.
REQ-012 o_imem_waddr  output  32  byte address of the write, always word-aligned.
REQ-013 o_imem_wdata  output  32  instruction word to write.
REQ-014 o_busy  output  1  a load is in progress.
REQ-015 o_done  output  1  the last load completed with a good checksum.
REQ-016 o_err  output  1  the last load failed.
REQ-017 o_cpu_hold  output  1  holds the core in reset while it is high.

Function
REQ-018 A byte SHALL be transferred only in a cycle where both i_byte_valid and o_byte_ready are high.
REQ-019 Stream format, bytes in order:
- LEN_LO, then LEN_HI, forming a 16-bit word count N;
- 4*N data bytes, each word little-endian (first byte is bits [7:0]);
- one checksum byte, equal to the XOR of all data bytes.
REQ-020 FSM states SHALL be IDLE, LEN0, LEN1, DATA, CSUM, DONE and ERR.
REQ-021 IDLE/DONE/ERR plus i_start SHALL go to LEN0, and the same cycle SHALL:
- clear o_done and o_err;
- set o_busy and o_cpu_hold;
- zero the word index and the running checksum.
REQ-022 i_start SHALL be ignored in LEN0, LEN1, DATA and CSUM.
REQ-023 o_byte_ready SHALL be high only in LEN0, LEN1, DATA and CSUM, and SHALL be a registered output.
REQ-024 Accepting a byte in LEN0 SHALL advance to LEN1.
REQ-025 Accepting a byte in LEN1 SHALL branch on N:
- N > DEPTH_WORDS goes to ERR;
- N == 0 goes to CSUM;
- otherwise goes to DATA.
REQ-026 In DATA, each accepted byte SHALL be XORed into the checksum and placed in the word assembly lane given by a 2-bit byte counter.
REQ-027 In the cycle after the 4th byte of a word is accepted, the block SHALL:
- pulse o_imem_we high for exactly one cycle;
- drive o_imem_waddr = BASE_ADDR + 4*index, with 32-bit modular arithmetic;
- drive o_imem_wdata = the assembled word;
- then increment the index.
REQ-028 After the write for word N-1 the FSM SHALL enter CSUM, and no data byte SHALL be lost when bytes arrive back-to-back.
REQ-029 Accepting a byte in CSUM SHALL go to DONE if it equals the running checksum, otherwise to ERR.
REQ-030 DONE SHALL hold o_done=1, o_busy=0 and o_cpu_hold=0.
REQ-031 ERR SHALL hold o_err=1, o_busy=0 and o_cpu_hold=1.
REQ-032 Gaps in i_byte_valid SHALL stall the FSM with no state change.
REQ-033 o_imem_waddr and o_imem_wdata SHALL hold their last values when o_imem_we is low.
REQ-034 The block SHALL never assert o_imem_we outside the DATA state or the cycle immediately following it.
REQ-035 At most N writes SHALL occur per load.

Reset
REQ-036 While rst_n is low, the block SHALL force the state to IDLE.
REQ-037 While rst_n is low, all outputs SHALL be 0 except o_cpu_hold, which SHALL equal BOOT_HOLD.
REQ-038 While rst_n is low, the byte counter, word index, checksum and assembly register SHALL be 0.
REQ-039 A reset in the middle of a load SHALL abort it with no further write, and a partially assembled word SHALL be discarded.

Verification
REQ-040 Good load: start, then 02 00 13 05 10 00 93 05 20 00 B0 -> two writes (0x0 <- 0x00100513, then 0x4 <- 0x00200593); o_done=1, o_cpu_hold=0.
REQ-041 Bad checksum: same stream ending in B1 -> both writes occur; o_err=1, o_done=0, o_cpu_hold=1.
REQ-042 Oversize length: start, then 01 08 (N=2049) -> ERR after LEN1 with no write; o_byte_ready=0 in the following cycle.
REQ-043 Empty load: start, then 00 00 00 -> DONE with zero writes; a checksum byte of 01 gives ERR instead.
REQ-044 Reset mid-load: rst_n pulsed after 02 00 13 05 -> no write and all outputs at reset values; a full REQ-040 sequence afterwards passes.
REQ-045 Stall and ignore: random i_byte_valid gaps plus an i_start pulse during DATA -> same writes and result as REQ-040, with the load not restarted.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream and writes it into instruction memory.
//
// The stream is LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes with
// little-endian words, then one checksum byte (XOR of all data bytes). Each
// assembled word is written one cycle after its 4th byte is accepted. The core
// is held in reset while a load runs and after a failed load.
//
// Handshake: a byte moves on a rising edge where i_byte_valid and o_byte_ready
// are both high. o_byte_ready is registered and is high only in LEN0, LEN1,
// DATA and CSUM. The source may drop i_byte_valid at any time; the FSM then
// holds still.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_start             one-cycle load request (honoured in IDLE/DONE/ERR only)
//   i_byte_valid        i_byte_data carries a stream byte
//   i_byte_data[7:0]    stream byte
//   o_byte_ready        byte accepted on this cycle's edge when valid is high
//   o_imem_we           one-cycle instruction-memory write strobe
//   o_imem_waddr[31:0]  word-aligned byte address (BASE_ADDR + 4*index)
//   o_imem_wdata[31:0]  assembled instruction word
//   o_busy              load in progress
//   o_done              last load completed with a good checksum
//   o_err               last load failed (oversize length or bad checksum)
//   o_cpu_hold          core held in reset while high
//   o_dbg_state[2:0]    current FSM state, for observation only
module imem_loader #(
  parameter int          DEPTH_WORDS = 2048,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic        BOOT_HOLD   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  output logic        o_byte_ready,
  output logic        o_imem_we,
  output logic [31:0] o_imem_waddr,
  output logic [31:0] o_imem_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_cpu_hold,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t      state, state_next;
  logic [1:0]  byte_cnt;
  logic [15:0] word_idx;
  logic [15:0] len_q;
  logic [7:0]  csum;
  logic [31:0] asm_word;

  logic        accept;
  logic        start_go;
  logic [15:0] n_full;
  logic        last_byte;
  logic        last_word;
  logic        busy_next;

  assign o_dbg_state = state;
  assign accept      = i_byte_valid & o_byte_ready;
  assign n_full      = {i_byte_data, len_q[7:0]};
  assign last_byte   = (byte_cnt == 2'd3);
  // word_idx counts words already written, so the word in flight is the last
  // one when word_idx + 1 reaches N.
  assign last_word   = ((word_idx + 16'd1) == len_q);
  assign start_go    = i_start &&
                       (state == S_IDLE || state == S_DONE || state == S_ERR);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (i_start) state_next = S_LEN0;
      S_LEN0: if (accept) state_next = S_LEN1;
      S_LEN1: begin
        if (accept) begin
          if (32'(n_full) > 32'(DEPTH_WORDS)) state_next = S_ERR;
          else if (n_full == 16'd0)           state_next = S_CSUM;
          else                                state_next = S_DATA;
        end
      end
      // Leaving DATA on the last byte puts the final write strobe in the
      // first CSUM cycle, so the checksum byte may follow back-to-back.
      S_DATA: if (accept && last_byte && last_word) state_next = S_CSUM;
      S_CSUM: begin
        if (accept) state_next = (i_byte_data == csum) ? S_DONE : S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy_next = (state_next == S_LEN0) || (state_next == S_LEN1) ||
                     (state_next == S_DATA) || (state_next == S_CSUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      o_byte_ready <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_cpu_hold   <= BOOT_HOLD;
      o_imem_we    <= 1'b0;
      o_imem_waddr <= 32'h0;
      o_imem_wdata <= 32'h0;
      byte_cnt     <= 2'd0;
      word_idx     <= 16'd0;
      len_q        <= 16'd0;
      csum         <= 8'h0;
      asm_word     <= 32'h0;
    end else begin
      state        <= state_next;
      o_byte_ready <= busy_next;
      o_busy       <= busy_next;
      o_done       <= (state_next == S_DONE);
      o_err        <= (state_next == S_ERR);
      // IDLE is only reachable through reset, where the boot policy applies.
      o_cpu_hold   <= (state_next == S_IDLE) ? BOOT_HOLD : (state_next != S_DONE);
      o_imem_we    <= 1'b0;

      if (start_go) begin
        byte_cnt <= 2'd0;
        word_idx <= 16'd0;
        csum     <= 8'h0;
        asm_word <= 32'h0;
      end

      if (accept) begin
        case (state)
          S_LEN0: len_q[7:0]  <= i_byte_data;
          S_LEN1: len_q[15:8] <= i_byte_data;
          S_DATA: begin
            csum     <= csum ^ i_byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              o_imem_we    <= 1'b1;
              o_imem_wdata <= {i_byte_data, asm_word[23:0]};
              o_imem_waddr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
              word_idx     <= word_idx + 16'd1;
            end else begin
              asm_word[8*byte_cnt +: 8] <= i_byte_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of complete load streams with their
// expected writes and final flags, plus hand sequences for oversize length,
// the N == DEPTH_WORDS boundary, reset in mid-load, and stalls with a stray
// start pulse.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_byte_valid;
  logic [7:0]  i_byte_data;
  logic        o_byte_ready;
  logic        o_imem_we;
  logic [31:0] o_imem_waddr;
  logic [31:0] o_imem_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_cpu_hold;
  logic [2:0]  o_dbg_state;

  imem_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_byte_valid (i_byte_valid),
    .i_byte_data  (i_byte_data),
    .o_byte_ready (o_byte_ready),
    .o_imem_we    (o_imem_we),
    .o_imem_waddr (o_imem_waddr),
    .o_imem_wdata (o_imem_wdata),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_cpu_hold   (o_cpu_hold),
    .o_dbg_state  (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: {addr, data} of every observed write vs expected
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  always @(negedge clk) begin
    if (o_imem_we) got_q.push_back({o_imem_waddr, o_imem_wdata});
  end

  typedef struct {
    logic [7:0]  bytes [12];
    int          nbytes;
    int          nwr;
    logic [63:0] wr [2];
    logic        done;
    logic        err;
    logic        hold;
  } vec_t;

  vec_t vecs [6];

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd6;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  // Present one byte after an optional random gap; returns once it has been
  // accepted on an edge (or the wait bound expires).
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int tries;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    i_byte_valid = 1'b0;
    repeat (gap) step();
    i_byte_valid = 1'b1;
    i_byte_data  = b;
    tries = 0;
    while (!o_byte_ready && tries < 50) begin
      step();
      tries++;
    end
    if (!o_byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: ready stayed 0 for byte %0h", b);
    end else begin
      step();
    end
    i_byte_valid = 1'b0;
  endtask

  task automatic compare_writes(input string name);
    chk({name, "_wr_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({name, "_wr"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic load_expect(input int idx);
    for (int k = 0; k < vecs[idx].nwr; k++) exp_q.push_back(vecs[idx].wr[k]);
  endtask

  task automatic check_result(input int idx, input string name);
    repeat (3) step();
    compare_writes(name);
    chk({name, "_done"}, 64'(o_done), 64'(vecs[idx].done));
    chk({name, "_err"}, 64'(o_err), 64'(vecs[idx].err));
    chk({name, "_hold"}, 64'(o_cpu_hold), 64'(vecs[idx].hold));
    chk({name, "_busy"}, 64'(o_busy), 64'd0);
    chk({name, "_ready"}, 64'(o_byte_ready), 64'd0);
  endtask

  task automatic run_vec(input int idx, input int max_gap);
    got_q.delete();
    load_expect(idx);
    pulse_start();
    chk($sformatf("v%0d_busy_after_start", idx), 64'(o_busy), 64'd1);
    for (int k = 0; k < vecs[idx].nbytes; k++) send_byte(vecs[idx].bytes[k], max_gap);
    check_result(idx, $sformatf("v%0d", idx));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_ready"}, 64'(o_byte_ready), 64'd0);
    chk({name, "_we"}, 64'(o_imem_we), 64'd0);
    chk({name, "_waddr"}, 64'(o_imem_waddr), 64'd0);
    chk({name, "_wdata"}, 64'(o_imem_wdata), 64'd0);
    chk({name, "_busy"}, 64'(o_busy), 64'd0);
    chk({name, "_done"}, 64'(o_done), 64'd0);
    chk({name, "_err"}, 64'(o_err), 64'd0);
    chk({name, "_hold"}, 64'(o_cpu_hold), 64'd0);
    chk({name, "_state"}, 64'(o_dbg_state), 64'(ST_IDLE));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check_reset_outputs("in_reset");
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    // good load
    vecs[0].bytes  = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0, 8'h00};
    vecs[0].nbytes = 11; vecs[0].nwr = 2;
    vecs[0].wr     = '{{32'h0, 32'h0010_0513}, {32'h4, 32'h0020_0593}};
    vecs[0].done = 1'b1; vecs[0].err = 1'b0; vecs[0].hold = 1'b0;
    // bad checksum: writes still happen
    vecs[1] = vecs[0];
    vecs[1].bytes[10] = 8'hB1;
    vecs[1].done = 1'b0; vecs[1].err = 1'b1; vecs[1].hold = 1'b1;
    // oversize N = 2049
    vecs[2].bytes  = '{8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2].nbytes = 2; vecs[2].nwr = 0; vecs[2].wr = '{64'h0, 64'h0};
    vecs[2].done = 1'b0; vecs[2].err = 1'b1; vecs[2].hold = 1'b1;
    // empty load, good checksum
    vecs[3].bytes  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].nbytes = 3; vecs[3].nwr = 0; vecs[3].wr = '{64'h0, 64'h0};
    vecs[3].done = 1'b1; vecs[3].err = 1'b0; vecs[3].hold = 1'b0;
    // empty load, bad checksum
    vecs[4] = vecs[3];
    vecs[4].bytes[2] = 8'h01;
    vecs[4].done = 1'b0; vecs[4].err = 1'b1; vecs[4].hold = 1'b1;
    // single word DEADBEEF, checksum EF^BE^AD^DE = 22
    vecs[5].bytes  = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[5].nbytes = 7; vecs[5].nwr = 1;
    vecs[5].wr     = '{{32'h0, 32'hDEAD_BEEF}, 64'h0};
    vecs[5].done = 1'b1; vecs[5].err = 1'b0; vecs[5].hold = 1'b0;

    rst_n = 1'b0; i_start = 1'b0; i_byte_valid = 1'b0; i_byte_data = 8'h00;
    #2;
    check_reset_outputs("reset");
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_reset_outputs("after_reset");

    // table: back-to-back bytes
    for (int i = 0; i < 6; i++) run_vec(i, 0);

    // oversize: ERR right after LEN1, ready low in the following cycle
    got_q.delete();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h08, 0);
    chk("oversize_state", 64'(o_dbg_state), 64'(ST_ERR));
    chk("oversize_ready", 64'(o_byte_ready), 64'd0);
    chk("oversize_err", 64'(o_err), 64'd1);
    step();
    chk("oversize_no_wr", 64'(got_q.size()), 64'd0);

    // N == DEPTH_WORDS is accepted, then abort by reset
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h08, 0);
    chk("depth_max_state", 64'(o_dbg_state), 64'(ST_DATA));
    chk("depth_max_ready", 64'(o_byte_ready), 64'd1);
    do_reset();

    // reset mid-load drops the partial word
    got_q.delete();
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h13, 0); send_byte(8'h05, 0);
    do_reset();
    repeat (2) step();
    chk("midreset_no_wr", 64'(got_q.size()), 64'd0);
    check_reset_outputs("midreset_after");
    run_vec(0, 0);

    // random stalls and a start pulse in DATA that must be ignored
    got_q.delete();
    load_expect(0);
    pulse_start();
    for (int k = 0; k < vecs[0].nbytes; k++) begin
      send_byte(vecs[0].bytes[k], 3);
      if (k == 5) begin
        pulse_start();
        chk("stall_start_ignored", 64'(o_dbg_state), 64'(ST_DATA));
      end
    end
    check_result(0, "stall");

    // stalled table run
    for (int i = 0; i < 6; i++) run_vec(i, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
